// File: rtl/imem_loader.sv
// Boot loader: packs a length-framed byte stream into 32-bit words and writes them to instruction RAM.
// Latency: imem_we pulses in the cycle after the 4th byte of a word is accepted.
// Backpressure: in_ready is low outside LEN_HI/LEN_LO/DATA; input stalls freeze all state, no timeout.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  // Largest legal word count is the RAM depth itself.
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  state_t state, state_nxt;

  logic [15:0]       len_q;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] word_cnt;
  logic [31:0]       asm_q;
  logic [31:0]       asm_nxt;
  logic [15:0]       len_now;
  logic              accept;
  logic              start_load;
  logic              len_zero;
  logic              len_big;
  logic              last_word;

  assign accept     = in_valid & in_ready;
  assign start_load = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));

  // Full length as it will be once the low byte in flight is stored.
  assign len_now  = {len_q[15:8], in_data};
  assign len_zero = (len_now == 16'd0);
  assign len_big  = ({1'b0, len_now} > DEPTH);

  // Word counter is compared in 17 bits so N = 2**ADDR_W never needs a wrapped counter.
  assign last_word = ({{(17-ADDR_W){1'b0}}, word_cnt} == ({1'b0, len_q} - 17'd1));

  // First byte of a word ends up in the top byte (MSB_FIRST) or the bottom byte.
  assign asm_nxt = MSB_FIRST ? {asm_q[23:0], in_data} : {in_data, asm_q[31:8]};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LEN_HI;
      S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_zero)     state_nxt = S_DONE;
          else if (len_big) state_nxt = S_ERR;
          else              state_nxt = S_DATA;
        end
      end
      S_DATA:   if (accept && byte_idx == 2'd3) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = last_word ? S_DONE : S_DATA;
      S_DONE:   if (start) state_nxt = S_LEN_HI;
      S_ERR:    if (start) state_nxt = S_LEN_HI;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are pure decodes of the registered state.
  always_comb begin
    in_ready    = 1'b0;
    imem_we     = 1'b0;
    cpu_reset_n = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
      end
      S_DONE: begin
        cpu_reset_n = 1'b1;
        done        = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // Datapath: length capture, word assembly, counters, and the held RAM address/data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q      <= '0;
      byte_idx   <= '0;
      word_cnt   <= '0;
      asm_q      <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      if (start_load) begin
        len_q    <= '0;
        byte_idx <= '0;
        word_cnt <= '0;
      end
      case (state)
        S_LEN_HI: if (accept) len_q[15:8] <= in_data;
        S_LEN_LO: begin
          if (accept) begin
            len_q[7:0] <= in_data;
            byte_idx   <= '0;
            word_cnt   <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            asm_q    <= asm_nxt;
            byte_idx <= byte_idx + 2'd1;
            // Latch the finished word so it is presented during WRITE and held afterwards.
            if (byte_idx == 2'd3) begin
              imem_addr  <= word_cnt;
              imem_wdata <= asm_nxt;
            end
          end
        end
        S_WRITE: if (!last_word) word_cnt <= word_cnt + ADDR_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: three instances (ADDR_W=10 MSB-first, ADDR_W=10 LSB-first, ADDR_W=2 MSB-first)
// driven one at a time with directed and random framed streams, compared against a list-of-words model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start    [3];
  logic        in_valid [3];
  logic [7:0]  in_data  [3];
  logic        in_ready [3];
  logic        imem_we  [3];
  logic        cpu_reset_n [3];
  logic        busy [3];
  logic        done [3];
  logic        err  [3];
  logic [31:0] imem_wdata [3];
  logic [9:0]  addr0;
  logic [9:0]  addr1;
  logic [1:0]  addr2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          inst;
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic [7:0] tx_q [$];
  int         acc_q [$];
  wr_t        got_q [$];

  imem_loader #(.ADDR_W(10), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .imem_we(imem_we[0]), .imem_addr(addr0), .imem_wdata(imem_wdata[0]),
    .cpu_reset_n(cpu_reset_n[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));

  imem_loader #(.ADDR_W(10), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .imem_we(imem_we[1]), .imem_addr(addr1), .imem_wdata(imem_wdata[1]),
    .cpu_reset_n(cpu_reset_n[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

  imem_loader #(.ADDR_W(2), .MSB_FIRST(1'b1)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .in_valid(in_valid[2]), .in_data(in_data[2]),
    .in_ready(in_ready[2]), .imem_we(imem_we[2]), .imem_addr(addr2), .imem_wdata(imem_wdata[2]),
    .cpu_reset_n(cpu_reset_n[2]), .busy(busy[2]), .done(done[2]), .err(err[2]));

  always #5 clk = ~clk;

  // Edge counter used to time-stamp byte accepts and write strobes.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int addr_of(input int i);
    case (i)
      0:       return int'(addr0);
      1:       return int'(addr1);
      default: return int'(addr2);
    endcase
  endfunction

  function automatic logic [47:0] outs(input int i);
    logic [9:0] a;
    a = 10'(addr_of(i));
    return {in_ready[i], imem_we[i], cpu_reset_n[i], busy[i], done[i], err[i], a, imem_wdata[i]};
  endfunction

  // Record every write strobe; a byte must never be accepted in a write cycle.
  always @(negedge clk) begin : mon
    wr_t w;
    for (int i = 0; i < 3; i++) begin
      if (imem_we[i] === 1'b1) begin
        w.inst = i;
        w.addr = addr_of(i);
        w.data = imem_wdata[i];
        w.cyc  = cyc;
        got_q.push_back(w);
        check("ready_in_write", 64'(in_ready[i]), 64'd0);
      end
    end
  end

  function automatic bit legal_len(input int n, input int aw);
    return (n >= 1) && (n <= (1 << aw));
  endfunction

  task automatic fill_random(input int n, input int aw);
    tx_q.delete();
    tx_q.push_back(8'(n >> 8));
    tx_q.push_back(8'(n));
    if (legal_len(n, aw))
      for (int k = 0; k < 4 * n; k++) tx_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic do_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  // Push the first nbytes of tx_q; stall=1 toggles in_valid randomly.
  task automatic send_bytes(input int i, input bit stall, input int nbytes);
    int sent = 0;
    bit v;
    for (int j = 0; j < nbytes && j < tx_q.size(); j++) begin
      for (int guard = 0; guard < 500; guard++) begin
        @(negedge clk);
        v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        in_valid[i] = v;
        in_data[i]  = v ? tx_q[j] : 8'($urandom_range(0, 255));
        if (v && in_ready[i] === 1'b1) begin
          if (j >= 2 && ((j - 2) % 4) == 3) acc_q.push_back(cyc + 1);
          sent++;
          break;
        end
      end
    end
    @(negedge clk);
    in_valid[i] = 1'b0;
    check("bytes_accepted", 64'(sent), 64'((nbytes < tx_q.size()) ? nbytes : tx_q.size()));
  endtask

  // Model: word k is bytes 4k..4k+3 of the payload placed by byte significance.
  task automatic verify(input int i, input int aw, input bit msb);
    int          n;
    int          nw;
    bit          ok_end;
    logic [31:0] w;
    n      = {24'd0, tx_q[0]} * 256 + {24'd0, tx_q[1]};
    ok_end = (n <= (1 << aw));
    nw     = legal_len(n, aw) ? n : 0;
    check("wr_count", 64'(got_q.size()), 64'(nw));
    for (int k = 0; k < nw && k < got_q.size(); k++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++)
        w = w | (32'(tx_q[2 + 4 * k + b]) << (msb ? (24 - 8 * b) : (8 * b)));
      check("wr_inst", 64'(got_q[k].inst), 64'(i));
      check("wr_addr", 64'(got_q[k].addr), 64'(k));
      check("wr_data", 64'(got_q[k].data), 64'(w));
      if (k < acc_q.size()) check("wr_latency", 64'(got_q[k].cyc), 64'(acc_q[k]));
    end
    check("end_done", 64'(done[i]), 64'(ok_end));
    check("end_err", 64'(err[i]), 64'(!ok_end));
    check("end_cpu_reset_n", 64'(cpu_reset_n[i]), 64'(ok_end));
    check("end_busy", 64'(busy[i]), 64'd0);
  endtask

  task automatic load(input int i, input int aw, input bit msb, input bit stall);
    acc_q.delete();
    got_q.delete();
    do_start(i);
    send_bytes(i, stall, tx_q.size());
    for (int k = 0; k < 50; k++) begin
      if (done[i] === 1'b1 || err[i] === 1'b1) break;
      @(negedge clk);
    end
    @(negedge clk);
    verify(i, aw, msb);
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = 8'd0;
    end

    // Reset and idle.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check("reset_outs", 64'(outs(i)), 64'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) check("idle_outs", 64'(outs(i)), 64'd0);

    // Two-word MSB-first load, continuous then stalled.
    tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    load(0, 10, 1'b1, 1'b0);
    if (got_q.size() == 2) begin
      check("two_word_w0", 64'(got_q[0].data), 64'h12345678);
      check("two_word_w1", 64'(got_q[1].data), 64'h9ABCDEF0);
    end
    load(0, 10, 1'b1, 1'b1);

    // LSB-first single word.
    tx_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    load(1, 10, 1'b0, 1'b1);
    if (got_q.size() == 1) check("lsb_word", 64'(got_q[0].data), 64'h44332211);

    // Random frames on both wide instances.
    for (int r = 0; r < 6; r++) begin
      fill_random($urandom_range(1, 6), 10);
      load(0, 10, 1'b1, 1'(r % 2));
      fill_random($urandom_range(1, 6), 10);
      load(1, 10, 1'b0, 1'(r % 2));
    end

    // Length boundaries on the 4-word RAM.
    fill_random(0, 2);     load(2, 2, 1'b1, 1'b0);
    fill_random(4, 2);     load(2, 2, 1'b1, 1'b1);
    fill_random(5, 2);     load(2, 2, 1'b1, 1'b0);
    fill_random(1, 2);     load(2, 2, 1'b1, 1'b0);
    fill_random(65535, 2); load(2, 2, 1'b1, 1'b1);
    fill_random(3, 2);     load(2, 2, 1'b1, 1'b1);

    // Length boundaries on the full-size RAM.
    fill_random(1024, 10); load(0, 10, 1'b1, 1'b0);
    fill_random(1025, 10); load(0, 10, 1'b1, 1'b0);
    fill_random(1, 10);    load(0, 10, 1'b1, 1'b0);

    // Asynchronous reset two bytes into the first word, then a clean reload.
    fill_random(2, 10);
    acc_q.delete();
    do_start(0);
    send_bytes(0, 1'b0, 4);
    check("mid_load_busy", 64'(busy[0]), 64'd1);
    #1 reset = 1'b0;
    #1 check("async_reset_outs", 64'(outs(0)), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    fill_random(2, 10);
    load(0, 10, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
